// File: rtl/decrypt_scheduler.sv
// decrypt_scheduler: buffers encrypted packets, dispatches each to the decrypt unit named by its
// function ID, waits a settle time, captures the result and returns results in arrival order.
module decrypt_scheduler #(
  parameter int NUM_FN     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [77:0]          in_data,
  output logic [NUM_FN-1:0]    fn_sel,
  output logic [77:0]          fn_data,
  input  logic [NUM_FN*61-1:0] fn_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [60:0]          out_data,
  output logic [2:0]           out_fn,
  output logic                 err,
  output logic [7:0]           err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // IDLE pop or drop | ISSUE drive unit | SETTLE_WAIT count down | HOLD wait for accept
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE_WAIT, HOLD} state_t;
  state_t state_q, state_d;

  logic [77:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop, drop, capture, fifo_empty, head_legal;
  logic [77:0]   head;

  logic [77:0]       pkt_q, pkt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [60:0]       out_data_q, out_data_d;
  logic [2:0]        out_fn_q, out_fn_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [60:0]       res_sel;
  logic [NUM_FN-1:0] sel_onehot;

  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_legal = (head[5:0] < 6'(NUM_FN));
  assign push       = in_valid && in_ready_q;
  assign drop       = pop && !head_legal;
  assign sel_onehot = NUM_FN'(1) << pkt_q[2:0];

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // registered from the next occupancy, so a pop while full does not reopen the input this cycle
    in_ready_d = (count_d != (AW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    res_sel = '0;
    for (int k = 0; k < NUM_FN; k++) begin
      if (pkt_q[2:0] == 3'(k)) res_sel = fn_result[61*k +: 61];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (!fifo_empty) state_d = head_legal ? ISSUE : IDLE;
      ISSUE:       state_d = SETTLE_WAIT;
      SETTLE_WAIT: if (cnt_q == 4'd0) state_d = HOLD;
      HOLD:        if (out_ready) state_d = (!fifo_empty && head_legal) ? ISSUE : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    fn_sel  = '0;
    case (state_q)
      IDLE:        pop = !fifo_empty;
      ISSUE:       fn_sel = sel_onehot;
      SETTLE_WAIT: begin
        fn_sel  = sel_onehot;
        capture = (cnt_q == 4'd0);
      end
      HOLD: begin
        fn_sel = sel_onehot;
        pop    = out_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    pkt_d       = pkt_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_fn_d    = out_fn_q;
    err_count_d = err_count_q;
    if (pop) pkt_d = head;
    if (state_q == ISSUE) cnt_d = 4'(SETTLE - 1);
    else if (state_q == SETTLE_WAIT && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = res_sel;
      out_fn_d    = pkt_q[2:0];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (drop && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      pkt_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_fn_q    <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      pkt_q       <= pkt_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_fn_q    <= out_fn_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign fn_data   = pkt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_fn    = out_fn_q;
  assign err       = drop;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_decrypt_scheduler.sv
// Testbench for decrypt_scheduler: table-driven single packets, hand-written corner sequences,
// and randomized traffic scored against a queue-based model of the scheduler.
module tb_decrypt_scheduler;
  localparam int NUM_FN     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int SETTLE     = 2;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [77:0]          in_data = '0;
  logic [NUM_FN-1:0]    fn_sel;
  logic [77:0]          fn_data;
  logic [NUM_FN*61-1:0] fn_result;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [60:0]          out_data;
  logic [2:0]           out_fn;
  logic                 err;
  logic [7:0]           err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [60:0] data;
    logic [2:0]  fn;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   exp_drops = 0;
  int   err_seen  = 0;

  typedef struct {
    logic [5:0]        id;
    logic [71:0]       body;
    int                exp_lat;
    int                exp_sel_cyc;
    logic [NUM_FN-1:0] exp_sel;
    int                exp_err;
  } vec_t;
  vec_t vecs[8];

  decrypt_scheduler #(.NUM_FN(NUM_FN), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE(SETTLE)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fn_sel(fn_sel), .fn_data(fn_data), .fn_result(fn_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_fn(out_fn),
    .err(err), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  // Each attached unit: a keyed transform of the packet body it is being driven with.
  function automatic logic [60:0] unit_out(int k, logic [77:0] d);
    logic [60:0] key;
    key = 61'h1E2_D3C4_B5A6_978 + 61'(k) * 61'h135_79BD_F024_68AC;
    return d[77:17] ^ key;
  endfunction

  always_comb begin
    fn_result = '0;
    for (int k = 0; k < NUM_FN; k++) fn_result[61*k +: 61] = unit_out(k, fn_data);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [77:0] d);
    exp_t e;
    if (int'(d[5:0]) >= NUM_FN) begin
      exp_drops++;
    end else begin
      e.data = unit_out(int'(d[5:0]), d);
      e.fn   = d[2:0];
      exp_q.push_back(e);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst) begin
      if (in_valid && in_ready) model_accept(in_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(mon_e.data));
          check("out_fn", 64'(out_fn), 64'(mon_e.fn));
        end
      end
      if (err) err_seen++;
    end
  end

  function automatic logic [77:0] make_pkt(input logic [5:0] id);
    logic [77:0] p;
    p[31:0]  = $urandom;
    p[63:32] = $urandom;
    p[77:64] = 14'($urandom);
    p[5:0]   = id;
    return p;
  endfunction

  function automatic logic [5:0] rand_id();
    if ($urandom_range(0, 9) < 2) return 6'($urandom_range(NUM_FN, 63));
    return 6'($urandom_range(0, NUM_FN - 1));
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_fn_sel"}, 64'(fn_sel), 64'(0));
    check({tag, "_fn_data_zero"}, 64'(fn_data == '0), 64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_fn"}, 64'(out_fn), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_err_count"}, 64'(err_count), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    Rst = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_vals(tag);
    exp_q.delete();
    exp_drops = 0;
    err_seen  = 0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
  endtask

  // Offers packets back to back; returns how many were accepted within the cycle budget.
  task automatic stream(input logic [77:0] pk[$], input int budget, output int accepted);
    int  idx;
    logic acc;
    idx = 0;
    in_valid = 1'b1;
    in_data  = pk[0];
    for (int c = 0; c < budget && idx < pk.size(); c++) begin
      acc = in_valid && in_ready;
      @(posedge Clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < pk.size()) in_data = pk[idx];
      end
    end
    in_valid = 1'b0;
    accepted = idx;
  endtask

  initial begin
    logic [77:0]       pkt;
    logic [77:0]       pk[$];
    logic [60:0]       got_data, hold_data;
    logic [2:0]        got_fn, hold_fn;
    logic [NUM_FN-1:0] selv, hold_sel;
    int                lat, selc, errs, tbl_err, accepted, sent, guard;
    logic              acc;

    vecs[0] = '{6'd2,  72'hA5A5_0123_4567_89AB_CD, 5, 4, 4'b0100, 0};
    vecs[1] = '{6'd0,  72'h1111_2222_3333_4444_55, 5, 4, 4'b0001, 0};
    vecs[2] = '{6'd3,  72'hFFFF_FFFF_FFFF_FFFF_FF, 5, 4, 4'b1000, 0};
    vecs[3] = '{6'd6,  72'h0BAD_0BAD_0BAD_0BAD_0B, 0, 0, 4'b0000, 1};
    vecs[4] = '{6'd1,  72'h5A5A_C3C3_0F0F_9696_E1, 5, 4, 4'b0010, 0};
    vecs[5] = '{6'd4,  72'h0000_0000_0000_0000_01, 0, 0, 4'b0000, 1};
    vecs[6] = '{6'd63, 72'h7777_8888_9999_AAAA_BB, 0, 0, 4'b0000, 1};
    vecs[7] = '{6'd2,  72'h0000_0000_0000_0000_00, 5, 4, 4'b0100, 0};

    do_reset("por");

    // Single packets from idle, out_ready held high.
    tbl_err = 0;
    for (int i = 0; i < 8; i++) begin
      pkt = {vecs[i].body, vecs[i].id};
      tbl_err += vecs[i].exp_err;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = pkt;
      check("tbl_in_ready_idle", 64'(in_ready), 64'(1));
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      lat = 0; selc = 0; selv = '0; errs = 0; got_data = '0; got_fn = '0;
      for (int c = 1; c <= 10; c++) begin
        if (fn_sel != '0) begin
          selc++;
          selv = fn_sel;
        end
        if (err) errs++;
        if (out_valid && lat == 0) begin
          lat = c;
          got_data = out_data;
          got_fn   = out_fn;
        end
        @(posedge Clk);
        #1;
      end
      check("tbl_latency", 64'(lat), 64'(vecs[i].exp_lat));
      check("tbl_sel_cycles", 64'(selc), 64'(vecs[i].exp_sel_cyc));
      check("tbl_sel_value", 64'(selv), 64'(vecs[i].exp_sel));
      check("tbl_err_pulses", 64'(errs), 64'(vecs[i].exp_err));
      if (vecs[i].exp_err == 0) begin
        check("tbl_out_data", 64'(got_data), 64'(unit_out(int'(vecs[i].id), pkt)));
        check("tbl_out_fn", 64'(got_fn), 64'(vecs[i].id[2:0]));
      end
    end
    check("tbl_err_count", 64'(err_count), 64'(tbl_err));

    // Fill while downstream stalls: one packet in flight plus a full FIFO.
    out_ready = 1'b0;
    pk.delete();
    pk.push_back(make_pkt(6'd1));
    pk.push_back(make_pkt(6'd3));
    pk.push_back(make_pkt(6'd0));
    pk.push_back(make_pkt(6'd2));
    pk.push_back(make_pkt(6'd1));
    pk.push_back(make_pkt(6'd3));
    stream(pk, 12, accepted);
    check("fill_accepted", 64'(accepted), 64'(FIFO_DEPTH + 1));
    check("fill_in_ready_low", 64'(in_ready), 64'(0));
    check("fill_out_valid", 64'(out_valid), 64'(1));
    check("fill_first_fn", 64'(out_fn), 64'(1));

    hold_data = out_data;
    hold_fn   = out_fn;
    hold_sel  = fn_sel;
    check("hold_sel_value", 64'(hold_sel), 64'(4'b0010));
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      #1;
      check("hold_out_data", 64'(out_data), 64'(hold_data));
      check("hold_out_fn", 64'(out_fn), 64'(hold_fn));
      check("hold_fn_sel", 64'(fn_sel), 64'(hold_sel));
    end
    out_ready = 1'b1;
    check("pop_full_in_ready", 64'(in_ready), 64'(0));
    @(posedge Clk);
    #1;
    check("b2b_issue_sel", 64'(fn_sel), 64'(4'b1000));
    check("b2b_out_valid_clr", 64'(out_valid), 64'(0));
    check("b2b_in_ready_back", 64'(in_ready), 64'(1));
    for (int g = 0; g < 300 && (exp_q.size() != 0 || out_valid); g++) begin
      @(posedge Clk);
      #1;
    end
    check("fill_drain", 64'(exp_q.size()), 64'(0));

    // Reset while a packet is in flight and another is queued.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = make_pkt(6'd2);
    @(posedge Clk);
    #1;
    in_data = make_pkt(6'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    @(posedge Clk);
    #1;
    check("pre_reset_busy", 64'(fn_sel), 64'(4'b0100));
    do_reset("mid");
    repeat (12) @(posedge Clk);
    #1;
    check("post_reset_quiet", 64'(out_valid), 64'(0));

    // Saturation of the drop counter.
    out_ready = 1'b1;
    pk.delete();
    for (int i = 0; i < 260; i++) pk.push_back(make_pkt(6'($urandom_range(NUM_FN, 63))));
    stream(pk, 2000, accepted);
    repeat (10) @(posedge Clk);
    #1;
    check("sat_accepted", 64'(accepted), 64'(260));
    check("sat_err_count", 64'(err_count), 64'(255));
    check("sat_err_pulses", 64'(err_seen), 64'(260));
    check("sat_no_output", 64'(out_valid), 64'(0));

    // Randomized traffic against the queue model.
    do_reset("rnd");
    sent  = 0;
    guard = 0;
    while (sent < 300 && guard < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = make_pkt(rand_id());
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      @(posedge Clk);
      #1;
      guard++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rnd_sent", 64'(sent), 64'(300));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 1000 && (exp_q.size() != 0 || out_valid); g++) begin
      @(posedge Clk);
      #1;
    end
    repeat (20) @(posedge Clk);
    #1;
    check("rnd_drain", 64'(exp_q.size()), 64'(0));
    check("rnd_err_count", 64'(err_count), 64'((exp_drops > 255) ? 255 : exp_drops));
    check("rnd_err_pulses", 64'(err_seen), 64'(exp_drops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end
endmodule
